// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// Instruction words, FSM encodings and PC step.
package if_stage_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_LOAD = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_stage_instr_mem.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module if_stage_instr_mem #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with LOAD/RUN/HALT sequencing.
// Optional perf counters enabled by IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_addr2jump,
    input  logic               i_start,
    input  logic               i_load_we,
    input  logic [NB_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0] i_load_data,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pc,
    output logic [1:0]         o_state,
    output logic               o_halted,
    output logic [31:0]        o_fetch_cnt,
    output logic [31:0]        o_flush_cnt
);

    localparam logic [NB_DATA-1:0] ALIGN = {{(NB_DATA-2){1'b1}}, 2'b00};

    logic [1:0]         state;
    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] fetch;
    logic               adv;
    logic               restart;

    assign adv     = (state == ST_RUN) & i_step & ~i_stall;
    assign restart = (state == ST_HALT) & i_start;

    if_stage_instr_mem #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk   (clk),
        .we    (i_load_we & (state == ST_LOAD)),
        .waddr (i_load_addr),
        .wdata (i_load_data),
        .raddr (pc[NB_ADDR+1:2]),
        .rdata (fetch)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_LOAD;
            pc            <= '0;
            o_instruction <= NB_DATA'(NOP);
            o_pc          <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (i_start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (adv) begin
                        if (i_jump) begin
                            // Flush the sequential fetch; no delay slot.
                            pc            <= i_addr2jump & ALIGN;
                            o_instruction <= NB_DATA'(NOP);
                            o_pc          <= '0;
                        end else if (fetch == NB_DATA'(HALT_INSTR)) begin
                            o_instruction <= fetch;
                            o_pc          <= pc;
                            state         <= ST_HALT;
                        end else begin
                            o_instruction <= fetch;
                            o_pc          <= pc;
                            pc            <= pc + NB_DATA'(PC_INC);
                        end
                    end
                end
                ST_HALT: begin
                    if (i_start) begin
                        state         <= ST_RUN;
                        pc            <= '0;
                        o_instruction <= NB_DATA'(NOP);
                        o_pc          <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign o_state  = state;
    assign o_halted = (state == ST_HALT);

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else if (restart) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (adv & ~i_jump & (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
            if (adv & i_jump & (flush_cnt != '1))  flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = fetch_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_fetch_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer end of the IF/ID interface.
- Holds the PC and the instruction memory. Registers {instruction, pc} into the IF/ID register consumed by the decode stage.
- Accepts the decode stage's jump redirect (jump flag + target), the hazard stall and the debug step.
- Provides a program-load mode and halt detection. A small FSM sequences LOAD -> RUN -> HALT.

Parameters:
- NB_DATA, 32, instruction/PC width
- NB_ADDR, 8, instruction-memory word-address bits (2^NB_ADDR words)

Ports:
- clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_step  in  1  advance enable; tie 1 for free-run, pulse for single-step
- i_stall  in  1  hazard stall: hold PC and IF/ID
- i_jump  in  1  redirect request from decode (same cycle as the instruction in IF/ID)
- i_addr2jump  in  NB_DATA  redirect target
- i_start  in  1  LOAD->RUN, or HALT->RUN restart
- i_load_we  in  1  program-memory write strobe (LOAD state only)
- i_load_addr  in  NB_ADDR  program word address
- i_load_data  in  NB_DATA  program word
- o_instruction  out  NB_DATA  IF/ID instruction
- o_pc  out  NB_DATA  byte address of o_instruction
- o_state  out  2  00 LOAD, 01 RUN, 10 HALT
- o_halted  out  1  1 in HALT state
- o_fetch_cnt  out  32  fetched-instruction count (optional feature)
- o_flush_cnt  out  32  flush count (optional feature)

Behaviour:
- Reset (async, immediate):
  - state=LOAD, PC=0
  - o_instruction=NOP (32'h0), o_pc=0, o_halted=0, counters=0
  - Instruction memory is not cleared.
- Fetch: asynchronous read of imem[PC[NB_ADDR+1:2]]. Address wraps modulo 2^NB_ADDR words. Fetch-to-IF/ID latency is 1 cycle.
- Advance condition: adv = (state==RUN) & i_step & ~i_stall.
- Priority each cycle: reset > ~i_step / i_stall (hold everything) > i_jump > HALT detect > normal.
- Normal (adv, no jump): IF/ID <= {imem[PC], PC}; PC <= PC+4.
- Jump (adv & i_jump):
  - PC <= {i_addr2jump[31:2], 2'b00}
  - IF/ID <= {NOP, 0}, flushing the sequential fetch
  - No delay slot.
  - Jump asserted while stalled or while i_step=0 is ignored; decode reasserts it.
- HALT detect (adv, ~i_jump, imem[PC]==32'hFFFFFFFF):
  - IF/ID <= {HALT, PC}; PC holds; state -> HALT.
  - If a jump is asserted in the same cycle, the flush wins: HALT is not captured and the state stays RUN.
- FSM:
  - LOAD: i_load_we writes imem; IF/ID holds NOP; PC=0. i_start -> RUN.
  - RUN: fetch as above. i_load_we is ignored.
  - HALT: PC, IF/ID and the HALT word are held, so decode keeps o_stop high. o_halted=1. i_load_we is ignored.
  - HALT + i_start -> RUN with PC=0 and IF/ID=NOP.
  - i_start in RUN is ignored.
- Simultaneous i_start and i_load_we in LOAD: the write is performed and the state moves to RUN.
- PC arithmetic: NB_DATA-bit modulo wrap.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - o_fetch_cnt increments on every normal or HALT capture.
  - o_flush_cnt increments on every jump flush.
  - Both counters saturate at 2^32-1 and clear on reset or on HALT->RUN restart.
- Undefined: both outputs are constant 0 and no counter flops are inferred.

Decomposition:
- Shared include/package holds:
  - NOP = 32'h00000000
  - HALT = 32'hFFFFFFFF
  - FSM encodings LOAD/RUN/HALT
  - PC increment constant 4
- Sub-module instr_mem: NB_ADDR x NB_DATA array, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Load imem[0..2]={0x20010005, 0x20020003, 0xFFFFFFFF}, pulse i_start, i_step=1 -> o_pc 0, 4, 8 on consecutive cycles; o_state=HALT after the HALT capture; o_instruction holds 0xFFFFFFFF and o_pc=8 indefinitely.
- RUN at PC=0x10, i_jump=1, i_addr2jump=0x43 -> next cycle o_instruction=0, o_pc=0; following cycle o_pc=0x40.
- i_stall=1 for 3 cycles at PC=0x08 with i_jump=1 -> PC and IF/ID are unchanged and the jump is ignored; after release, the normal fetch resumes at 0x08.
- HALT at imem[3] with i_jump=1 in the same cycle targeting 0x0 -> IF/ID=NOP, state stays RUN, fetch restarts at 0.
- i_step held 0 for 5 cycles in RUN -> PC and outputs are frozen; a single 1-cycle pulse advances exactly one fetch.
- Assert i_reset mid-RUN at PC=0x1C -> outputs clear immediately (asynchronously), state=LOAD, and imem contents survive (refetch after i_start returns the same words). With IF_PERF_CNT_EN defined, the counters read 0.
